// File: rtl/gate_test_sequencer.sv
// Clocked stimulus/check sequencer for a 2-input gate under test.
// Define GATE_TEST_LOOP_EN to loop over the four vectors forever.
module gate_test_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [3:0]  TRUTH       = 4'b0111,
  parameter int unsigned ERR_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gate_out,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [1:0]       vec, vec_n;
  logic [7:0]       hold_cnt, hold_n;
  logic             busy_n, done_n, pass_n;
  logic             gate_a_n, gate_b_n;
  logic [ERR_W-1:0] err_n;
  logic [3:0]       fail_n;

  always_comb begin
    state_n = state;
    vec_n   = vec;
    hold_n  = hold_cnt;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_count;
    fail_n  = fail_vec;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          vec_n   = 2'd0;
          hold_n  = 8'd0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          fail_n  = 4'b0000;
        end
      end
      APPLY: begin
        hold_n = hold_cnt + 8'd1;
        if (hold_cnt == HOLD_LAST) begin
          // gate is combinational off the registered inputs
          if (gate_out != TRUTH[vec]) begin
            fail_n[vec] = 1'b1;
            if (err_count != '1)
              err_n = err_count + 1'b1;
          end
          hold_n = 8'd0;
          if (vec != 2'd3) begin
            vec_n = vec + 2'd1;
          end else begin
`ifdef GATE_TEST_LOOP_EN
            vec_n = 2'd0;
`else
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (fail_n == 4'b0000);
`endif
          end
        end
`ifdef GATE_TEST_LOOP_EN
        pass_n = (fail_n == 4'b0000);
`endif
      end
      default: state_n = IDLE;
    endcase
    gate_a_n = (state_n == APPLY) & vec_n[1];
    gate_b_n = (state_n == APPLY) & vec_n[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= 2'd0;
      hold_cnt  <= 8'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= 4'b0000;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      hold_cnt  <= hold_n;
      gate_a    <= gate_a_n;
      gate_b    <= gate_b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer (single-pass build).
// Gate models: NAND, AND, stuck-at-1.
module tb_gate_test_sequencer;

  localparam int         HOLD  = 4;
  localparam logic [3:0] TT    = 4'b0111;
  localparam int         EW    = 3;

  typedef struct {
    logic [3:0]    fv;
    logic [EW-1:0] ec;
    logic          ps;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          gate_out;
  logic          gate_a, gate_b, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [3:0]    fail_vec;
  int            mode = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] vec_q[$];
  res_t       res_q[$];

  gate_test_sequencer #(
    .HOLD_CYCLES(HOLD),
    .TRUTH(TT),
    .ERR_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .gate_out(gate_out),
    .gate_a(gate_a),
    .gate_b(gate_b),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic model(int m, logic a, logic b);
    case (m)
      0:       return ~(a & b);
      1:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  always_comb gate_out = model(mode, gate_a, gate_b);

  task automatic check_idle(string name);
    n_cmp++;
    if ({gate_a, gate_b, busy, done, pass, err_count, fail_vec} !== '0) begin
      n_err++;
      $display("FAIL %s: got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
               name, gate_a, gate_b, busy, done, pass, err_count, fail_vec);
    end
  endtask

  task automatic push_expected(int m);
    res_t r;
    int   e;
    logic [1:0] v;
    r.fv = 4'b0000;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      for (int h = 0; h < HOLD; h++) vec_q.push_back(v);
      if (model(m, v[1], v[0]) !== TT[i]) begin
        r.fv[i] = 1'b1;
        e++;
      end
    end
    r.ec = (e > 7) ? 3'd7 : EW'(e);
    r.ps = (r.fv == 4'b0000);
    res_q.push_back(r);
  endtask

  task automatic run(string name, int m, int pulse_at, int reset_at);
    int   cycles;
    bit   aborted;
    logic [1:0] exp_ab;
    res_t r;
    mode = m;
    push_expected(m);
    @(negedge clk);
    start = 1'b1;
    cycles = 0;
    aborted = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      if (!busy) break;
      cycles++;
      if (cycles == 1) begin
        n_cmp++;
        if ({done, pass, err_count, fail_vec} !== '0) begin
          n_err++;
          $display("FAIL %s entry: got done=%b pass=%b err=%0d fv=%b want 0",
                   name, done, pass, err_count, fail_vec);
        end
      end
      exp_ab = (vec_q.size() > 0) ? vec_q.pop_front() : 2'bxx;
      n_cmp++;
      if ({gate_a, gate_b} !== exp_ab) begin
        n_err++;
        $display("FAIL %s ab@%0d: got %b%b want %b", name, cycles, gate_a, gate_b, exp_ab);
      end
      if (cycles == pulse_at) start = 1'b1;
      if (cycles == reset_at) begin
        reset = 1'b1;
        aborted = 1;
      end
    end
    if (aborted) begin
      vec_q.delete();
      res_q.delete();
      check_idle({name, " after reset"});
      return;
    end
    n_cmp++;
    if (cycles != 4 * HOLD) begin
      n_err++;
      $display("FAIL %s busy_len: got %0d want %0d", name, cycles, 4 * HOLD);
    end
    r = res_q.pop_front();
    n_cmp++;
    if ({done, pass, err_count, fail_vec, gate_a, gate_b} !==
        {1'b1, r.ps, r.ec, r.fv, 2'b00}) begin
      n_err++;
      $display("FAIL %s result: got done=%b pass=%b err=%0d fv=%b ab=%b%b want 1 %b %0d %b 00",
               name, done, pass, err_count, fail_vec, gate_a, gate_b, r.ps, r.ec, r.fv);
    end
    vec_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_idle("reset_start");
    repeat (2) @(negedge clk);
    check_idle("reset_start_hold");
  endtask

  task automatic test_nand;
    run("nand", 0, 0, 0);
  endtask

  task automatic test_and;
    run("and", 1, 0, 0);
  endtask

  task automatic test_stuck_back_to_back;
    run("stuck1", 2, 0, 0);
    run("stuck1_rerun", 2, 0, 0);
  endtask

  task automatic test_start_ignored;
    run("start_mid", 0, 5, 0);
  endtask

  task automatic test_reset_mid;
    run("reset_mid", 1, 0, 6);
    repeat (2) @(negedge clk);
    check_idle("reset_mid_idle");
    run("after_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_and();
    test_stuck_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
